axi_mm_top: RTL and testbench

AXI_MM_TOP -- requirements
Module: axi_mm_top

---
 rtl/axi_mm_top.sv | 171 +++++++++++++++++
 tb/tb_axi_mm_top.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mm_top.sv
// AXI4 memory-mapped slave over a MEM_DEPTH x 64-bit array, one outstanding burst per direction.
// Optional macro AXI_MM_TOP_DECERR_EN: out-of-range start addresses answer DECERR instead of aliasing.
module axi_mm_top #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_DEPTH      = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    input  logic [AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    input  logic [1:0]                  M_AXI_AWBURST,
    input  logic [2:0]                  M_AXI_AWSIZE,
    input  logic [7:0]                  M_AXI_AWLEN,
    input  logic                        M_AXI_AWVALID,
    output logic                        M_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    input  logic                        M_AXI_WLAST,
    input  logic                        M_AXI_WVALID,
    output logic                        M_AXI_WREADY,
    output logic [AXI_ID_WIDTH-1:0]     M_AXI_BID,
    output logic [1:0]                  M_AXI_BRESP,
    output logic                        M_AXI_BVALID,
    input  logic                        M_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    input  logic [AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    input  logic [1:0]                  M_AXI_ARBURST,
    input  logic [2:0]                  M_AXI_ARSIZE,
    input  logic [7:0]                  M_AXI_ARLEN,
    input  logic                        M_AXI_ARVALID,
    output logic                        M_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    output logic [AXI_ID_WIDTH-1:0]     M_AXI_RID,
    output logic [1:0]                  M_AXI_RRESP,
    output logic                        M_AXI_RLAST,
    output logic                        M_AXI_RVALID,
    input  logic                        M_AXI_RREADY
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic                      rdy_en;
    logic [AXI_ADDR_WIDTH-1:0] w_addr, r_addr, r_addr_nxt;
    logic [1:0]                w_burst, r_burst;
    logic [AXI_ID_WIDTH-1:0]   w_id, r_id;
    logic [7:0]                r_len, r_cnt;
    logic                      w_err, r_err, aw_err, ar_err;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last;
    logic                      unused_ok;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

`ifdef AXI_MM_TOP_DECERR_EN
    assign aw_err = |M_AXI_AWADDR[AXI_ADDR_WIDTH-1:IDX_W+3];
    assign ar_err = |M_AXI_ARADDR[AXI_ADDR_WIDTH-1:IDX_W+3];
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    assign unused_ok = ^{M_AXI_AWSIZE, M_AXI_AWLEN, M_AXI_ARSIZE};

    // Ready stays low until the first edge after reset release.
    assign M_AXI_AWREADY = rdy_en && (w_state == W_IDLE);
    assign M_AXI_WREADY  = (w_state == W_DATA);
    assign M_AXI_BVALID  = (w_state == W_RESP);
    assign M_AXI_BID     = w_id;
    assign M_AXI_BRESP   = w_err ? 2'b11 : 2'b00;
    assign M_AXI_ARREADY = rdy_en && (r_state == R_IDLE);
    assign M_AXI_RVALID  = (r_state == R_DATA);
    assign M_AXI_RLAST   = M_AXI_RVALID && r_last;
    assign M_AXI_RID     = r_id;
    assign M_AXI_RRESP   = r_err ? 2'b11 : 2'b00;
    assign M_AXI_RDATA   = r_data;

    assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs   = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs   = M_AXI_BVALID && M_AXI_BREADY;
    assign ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs   = M_AXI_RVALID && M_AXI_RREADY;
    assign r_last = (r_cnt == r_len);
    assign r_addr_nxt = (r_burst == BURST_FIXED) ? r_addr : r_addr + BEAT_BYTES;

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && M_AXI_WLAST) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && r_last) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    // Read data is prefetched into a register so a stalled beat cannot change under a later write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en  <= 1'b0;
            w_addr  <= '0;
            w_burst <= '0;
            w_id    <= '0;
            w_err   <= 1'b0;
            r_addr  <= '0;
            r_burst <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (aw_hs) begin
                w_addr  <= M_AXI_AWADDR;
                w_burst <= M_AXI_AWBURST;
                w_id    <= M_AXI_AWID;
                w_err   <= aw_err;
            end else if (w_hs && (w_burst != BURST_FIXED)) begin
                w_addr <= w_addr + BEAT_BYTES;
            end
            if (ar_hs) begin
                r_addr  <= M_AXI_ARADDR;
                r_burst <= M_AXI_ARBURST;
                r_id    <= M_AXI_ARID;
                r_len   <= M_AXI_ARLEN;
                r_cnt   <= '0;
                r_err   <= ar_err;
                r_data  <= ar_err ? '0 : mem[M_AXI_ARADDR[3 +: IDX_W]];
            end else if (r_hs) begin
                r_addr <= r_addr_nxt;
                r_cnt  <= r_cnt + 8'd1;
                if (!r_last) r_data <= r_err ? '0 : mem[r_addr_nxt[3 +: IDX_W]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && !w_err) begin
            for (int b = 0; b < AXI_DATA_WIDTH/8; b++) begin
                if (M_AXI_WSTRB[b]) mem[w_addr[3 +: IDX_W]][b*8 +: 8] <= M_AXI_WDATA[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_mm_top.sv
// Bench for axi_mm_top: directed scenarios plus randomized bursts checked against a word/byte memory model.
module tb_axi_mm_top;
    localparam int DEPTH = 256;
`ifdef AXI_MM_TOP_DECERR_EN
    localparam bit DECERR = 1'b1;
`else
    localparam bit DECERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] M_AXI_AWADDR = '0, M_AXI_ARADDR = '0;
    logic [3:0]  M_AXI_AWID = '0, M_AXI_ARID = '0, M_AXI_BID, M_AXI_RID;
    logic [1:0]  M_AXI_AWBURST = '0, M_AXI_ARBURST = '0, M_AXI_BRESP, M_AXI_RRESP;
    logic [2:0]  M_AXI_AWSIZE = '0, M_AXI_ARSIZE = '0;
    logic [7:0]  M_AXI_AWLEN = '0, M_AXI_ARLEN = '0, M_AXI_WSTRB = '0;
    logic [63:0] M_AXI_WDATA = '0, M_AXI_RDATA;
    logic M_AXI_AWVALID = 0, M_AXI_WLAST = 0, M_AXI_WVALID = 0, M_AXI_BREADY = 0;
    logic M_AXI_ARVALID = 0, M_AXI_RREADY = 0;
    logic M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RLAST, M_AXI_RVALID;

    axi_mm_top dut (
        .clk(clk), .rst_n(rst_n),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARID(M_AXI_ARID),
        .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference memory: word contents plus per-byte "known" flags (memory is not reset).
    logic [63:0] ref_mem [DEPTH];
    logic [7:0]  ref_bv  [DEPTH];

    // Write stimulus and collected read results.
    logic [63:0] wdat [256];
    logic [7:0]  wstb [256];
    logic [63:0] rdat [256];
    logic        rlst [256];
    logic [3:0]  rid_a [256];
    logic [1:0]  rrsp [256];
    int rcount, rlat, runstable;
    logic       bgot;
    logic [1:0] bresp_o;
    logic [3:0] bid_o;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 3) % DEPTH);
    endfunction

    function automatic bit exp_err(input logic [31:0] start);
        return DECERR && (start >= DEPTH * 8);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [1:0] burst, input int i);
        return (burst == 2'b00) ? start : start + 32'(8 * i);
    endfunction

    function automatic void model_write(input logic [31:0] start, input logic [1:0] burst, input int nb);
        int idx;
        if (exp_err(start)) return;
        for (int i = 0; i < nb; i++) begin
            idx = widx(beat_addr(start, burst, i));
            for (int b = 0; b < 8; b++) begin
                if (wstb[i][b]) begin
                    ref_mem[idx][b*8 +: 8] = wdat[i][b*8 +: 8];
                    ref_bv[idx][b] = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [63:0] exp_data(input logic [31:0] start, input logic [1:0] burst, input int i);
        return exp_err(start) ? 64'h0 : ref_mem[widx(beat_addr(start, burst, i))];
    endfunction

    function automatic logic [63:0] exp_mask(input logic [31:0] start, input logic [1:0] burst, input int i);
        logic [63:0] m;
        logic [7:0] bv;
        bv = exp_err(start) ? 8'hFF : ref_bv[widx(beat_addr(start, burst, i))];
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{bv[b]}};
        return m;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [1:0] burst,
                             input int nb, input bit gaps, input bit do_b);
        int t;
        @(negedge clk);
        M_AXI_AWADDR = addr; M_AXI_AWID = id; M_AXI_AWBURST = burst;
        M_AXI_AWSIZE = 3'd3; M_AXI_AWLEN = 8'(nb - 1); M_AXI_AWVALID = 1'b1;
        t = 0;
        while (!M_AXI_AWREADY && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            vectors++; miscompares++;
            $display("FAIL aw_timeout: AWREADY=%b after %0d cycles, want 1", M_AXI_AWREADY, t);
        end
        @(negedge clk);
        M_AXI_AWVALID = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            M_AXI_WVALID = 1'b1; M_AXI_WDATA = wdat[i]; M_AXI_WSTRB = wstb[i];
            M_AXI_WLAST = (i == nb - 1);
            t = 0;
            while (!M_AXI_WREADY && t < 200) begin @(negedge clk); t++; end
            if (t >= 200) begin
                vectors++; miscompares++;
                $display("FAIL w_timeout: WREADY=%b beat %0d, want 1", M_AXI_WREADY, i);
            end
            @(negedge clk);
            M_AXI_WVALID = 1'b0; M_AXI_WLAST = 1'b0;
        end
        bgot = 1'b0;
        if (do_b) begin
            M_AXI_BREADY = 1'b1;
            t = 0;
            while (!M_AXI_BVALID && t < 200) begin @(negedge clk); t++; end
            if (M_AXI_BVALID) begin bgot = 1'b1; bresp_o = M_AXI_BRESP; bid_o = M_AXI_BID; end
            @(negedge clk);
            M_AXI_BREADY = 1'b0;
        end
    endtask

    // mode 0: RREADY always 1; 1: toggles 1/0; 2: random.
    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [1:0] burst,
                            input int len, input int mode);
        int t;
        logic [63:0] hd;
        logic hl;
        bit holding;
        rcount = 0; runstable = 0; rlat = -1; holding = 0; hd = '0; hl = 1'b0;
        @(negedge clk);
        M_AXI_ARADDR = addr; M_AXI_ARID = id; M_AXI_ARBURST = burst;
        M_AXI_ARSIZE = 3'd3; M_AXI_ARLEN = 8'(len); M_AXI_ARVALID = 1'b1;
        t = 0;
        while (!M_AXI_ARREADY && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        M_AXI_ARVALID = 1'b0;
        t = 0;
        while (rcount <= len && t < 2000) begin
            case (mode)
                0:       M_AXI_RREADY = 1'b1;
                1:       M_AXI_RREADY = (t % 2 == 0);
                default: M_AXI_RREADY = 1'($urandom_range(0, 1));
            endcase
            if (M_AXI_RVALID) begin
                if (rlat < 0) rlat = t;
                if (holding && (M_AXI_RDATA !== hd || M_AXI_RLAST !== hl)) runstable++;
                if (M_AXI_RREADY) begin
                    rdat[rcount] = M_AXI_RDATA; rlst[rcount] = M_AXI_RLAST;
                    rid_a[rcount] = M_AXI_RID; rrsp[rcount] = M_AXI_RRESP;
                    rcount++; holding = 0;
                end else begin
                    hd = M_AXI_RDATA; hl = M_AXI_RLAST; holding = 1;
                end
            end
            @(negedge clk);
            t++;
        end
        M_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RLAST} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: aw/w/b/ar/rv/rl=%b want 000000", {M_AXI_AWREADY, M_AXI_WREADY,
                     M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RLAST});
        end
        vectors++;
        if ({M_AXI_BID, M_AXI_BRESP, M_AXI_RID, M_AXI_RRESP, M_AXI_RDATA} !== 76'h0) begin
            miscompares++;
            $display("FAIL reset_data: bid=%h bresp=%b rid=%h rresp=%b rdata=%h want all 0",
                     M_AXI_BID, M_AXI_BRESP, M_AXI_RID, M_AXI_RRESP, M_AXI_RDATA);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({M_AXI_AWREADY, M_AXI_ARREADY} !== 2'b00) begin
            miscompares++;
            $display("FAIL ready_before_edge: aw/ar=%b want 00", {M_AXI_AWREADY, M_AXI_ARREADY});
        end
        @(posedge clk); #1;
        vectors++;
        if ({M_AXI_AWREADY, M_AXI_ARREADY} !== 2'b11) begin
            miscompares++;
            $display("FAIL ready_after_edge: aw/ar=%b want 11", {M_AXI_AWREADY, M_AXI_ARREADY});
        end
    endtask

    task automatic test_single();
        wdat[0] = 64'h1122334455667788; wstb[0] = 8'hFF;
        axi_write(32'h0, 4'd0, 2'b01, 1, 0, 1);
        model_write(32'h0, 2'b01, 1);
        vectors++;
        if ({bgot, bid_o, bresp_o} !== {1'b1, 4'd0, 2'b00}) begin
            miscompares++;
            $display("FAIL single_b: got=%b bid=%0d bresp=%b want 1/0/00", bgot, bid_o, bresp_o);
        end
        axi_read(32'h0, 4'd3, 2'b01, 0, 0);
        vectors++;
        if (rcount !== 1 || rdat[0] !== 64'h1122334455667788) begin
            miscompares++;
            $display("FAIL single_r_data: beats=%0d data=%h want 1/1122334455667788", rcount, rdat[0]);
        end
        vectors++;
        if ({rid_a[0], rlst[0], rrsp[0]} !== {4'd3, 1'b1, 2'b00}) begin
            miscompares++;
            $display("FAIL single_r_meta: rid=%0d rlast=%b rresp=%b want 3/1/00", rid_a[0], rlst[0], rrsp[0]);
        end
        vectors++;
        if (rlat !== 0) begin
            miscompares++;
            $display("FAIL r_latency: first RVALID %0d cycles late, want 0", rlat);
        end
    endtask

    task automatic test_strobe();
        wdat[0] = 64'hFFFFFFFFFFFFFFFF; wstb[0] = 8'h0F;
        axi_write(32'h0, 4'd1, 2'b01, 1, 0, 1);
        model_write(32'h0, 2'b01, 1);
        axi_read(32'h0, 4'd2, 2'b01, 0, 0);
        vectors++;
        if (rdat[0] !== 64'h11223344FFFFFFFF) begin
            miscompares++;
            $display("FAIL strobe: data=%h want 11223344ffffffff", rdat[0]);
        end
    endtask

    task automatic test_burst_stall();
        for (int i = 0; i < 4; i++) begin wdat[i] = 64'(i + 1); wstb[i] = 8'hFF; end
        axi_write(32'h40, 4'd7, 2'b01, 4, 0, 1);
        model_write(32'h40, 2'b01, 4);
        axi_read(32'h40, 4'd9, 2'b01, 3, 1);
        vectors++;
        if (rcount !== 4 || runstable !== 0) begin
            miscompares++;
            $display("FAIL burst_stall: beats=%0d unstable=%0d want 4/0", rcount, runstable);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rdat[i] !== 64'(i + 1) || rlst[i] !== (i == 3) || rid_a[i] !== 4'd9) begin
                miscompares++;
                $display("FAIL burst_beat%0d: data=%h rlast=%b rid=%0d want %0d/%b/9",
                         i, rdat[i], rlst[i], rid_a[i], i + 1, (i == 3));
            end
        end
    endtask

    task automatic test_bresp_hold();
        wdat[0] = {$urandom, $urandom}; wstb[0] = 8'hFF;
        axi_write(32'h100, 4'd5, 2'b01, 1, 0, 0);
        model_write(32'h100, 2'b01, 1);
        M_AXI_AWADDR = 32'h108; M_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({M_AXI_BVALID, M_AXI_AWREADY} !== 2'b10) begin
                miscompares++;
                $display("FAIL b_hold%0d: bvalid/awready=%b want 10", i, {M_AXI_BVALID, M_AXI_AWREADY});
            end
            @(negedge clk);
        end
        M_AXI_BREADY = 1'b1;
        vectors++;
        if ({M_AXI_BVALID, M_AXI_BID, M_AXI_AWREADY} !== {1'b1, 4'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL b_release: bvalid=%b bid=%0d awready=%b want 1/5/0", M_AXI_BVALID, M_AXI_BID, M_AXI_AWREADY);
        end
        @(negedge clk);
        M_AXI_BREADY = 1'b0; M_AXI_AWVALID = 1'b0;
        vectors++;
        if ({M_AXI_BVALID, M_AXI_AWREADY} !== 2'b01) begin
            miscompares++;
            $display("FAIL b_done: bvalid/awready=%b want 01", {M_AXI_BVALID, M_AXI_AWREADY});
        end
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 4; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
        fork
            axi_write(32'h320, 4'd2, 2'b01, 4, 1, 1);
            axi_read(32'h40, 4'd4, 2'b01, 3, 2);
        join
        model_write(32'h320, 2'b01, 4);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rdat[i] !== exp_data(32'h40, 2'b01, i) || rlst[i] !== (i == 3)) begin
                miscompares++;
                $display("FAIL conc_read%0d: data=%h rlast=%b want %h/%b", i, rdat[i], rlst[i],
                         exp_data(32'h40, 2'b01, i), (i == 3));
            end
        end
        axi_read(32'h320, 4'd4, 2'b01, 3, 0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rdat[i] !== wdat[i]) begin
                miscompares++;
                $display("FAIL conc_write%0d: data=%h want %h", i, rdat[i], wdat[i]);
            end
        end
    endtask

    task automatic test_high_addr();
`ifdef AXI_MM_TOP_DECERR_EN
        wdat[0] = 64'hDEADBEEFDEADBEEF; wstb[0] = 8'hFF;
        axi_write(32'h80000000, 4'd6, 2'b01, 1, 0, 1);
        vectors++;
        if ({bgot, bresp_o} !== 3'b111) begin
            miscompares++;
            $display("FAIL decerr_b: got=%b bresp=%b want 1/11", bgot, bresp_o);
        end
`endif
        axi_read(32'h80000000, 4'd8, 2'b01, 0, 0);
        vectors++;
        if (rdat[0] !== (DECERR ? 64'h0 : ref_mem[0]) || rrsp[0] !== (DECERR ? 2'b11 : 2'b00)) begin
            miscompares++;
            $display("FAIL high_addr: data=%h rresp=%b want %h/%b", rdat[0], rrsp[0],
                     DECERR ? 64'h0 : ref_mem[0], DECERR ? 2'b11 : 2'b00);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [1:0] burst;
        logic [3:0] id;
        int len;
        for (int it = 0; it < 16; it++) begin
            addr  = 32'($urandom_range(0, DEPTH - 1) * 8);
            if ($urandom_range(0, 3) == 0) addr[31] = 1'b1;
            burst = 2'($urandom_range(0, 2));
            id    = 4'($urandom_range(0, 15));
            len   = $urandom_range(0, 7);
            for (int i = 0; i <= len; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'($urandom); end
            axi_write(addr, id, burst, len + 1, 1, 1);
            model_write(addr, burst, len + 1);
            vectors++;
            if ({bgot, bid_o, bresp_o} !== {1'b1, id, exp_err(addr) ? 2'b11 : 2'b00}) begin
                miscompares++;
                $display("FAIL rand_b%0d: got=%b bid=%0d bresp=%b want 1/%0d/%b", it, bgot, bid_o, bresp_o,
                         id, exp_err(addr) ? 2'b11 : 2'b00);
            end
            axi_read(addr, ~id, burst, len, 2);
            vectors++;
            if (rcount !== len + 1 || runstable !== 0) begin
                miscompares++;
                $display("FAIL rand_count%0d: beats=%0d unstable=%0d want %0d/0", it, rcount, runstable, len + 1);
            end
            for (int i = 0; i < rcount; i++) begin
                vectors++;
                if ((rdat[i] & exp_mask(addr, burst, i)) !== (exp_data(addr, burst, i) & exp_mask(addr, burst, i)) ||
                    {rlst[i], rid_a[i], rrsp[i]} !== {(i == len), ~id, exp_err(addr) ? 2'b11 : 2'b00}) begin
                    miscompares++;
                    $display("FAIL rand_beat%0d_%0d: data=%h last=%b rid=%0d resp=%b want %h(mask %h)/%b/%0d",
                             it, i, rdat[i], rlst[i], rid_a[i], rrsp[i], exp_data(addr, burst, i),
                             exp_mask(addr, burst, i), (i == len), ~id);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        axi_read(32'h40, 4'd1, 2'b01, 3, 3);
        @(negedge clk);
        M_AXI_ARADDR = 32'h40; M_AXI_ARLEN = 8'd3; M_AXI_ARVALID = 1'b1;
        @(negedge clk);
        M_AXI_ARVALID = 1'b0;
        @(negedge clk);
        vectors++;
        if (M_AXI_RVALID !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rvalid: RVALID=%b want 1", M_AXI_RVALID);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({M_AXI_RVALID, M_AXI_RLAST, M_AXI_ARREADY, M_AXI_RDATA} !== 67'h0) begin
            miscompares++;
            $display("FAIL mid_reset: rvalid/rlast/arready=%b rdata=%h want 000/0",
                     {M_AXI_RVALID, M_AXI_RLAST, M_AXI_ARREADY}, M_AXI_RDATA);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({M_AXI_RVALID, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_AWREADY} !== 4'b0011) begin
            miscompares++;
            $display("FAIL after_mid_reset: rv/bv/ar/aw=%b want 0011",
                     {M_AXI_RVALID, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_AWREADY});
        end
        axi_read(32'h40, 4'd2, 2'b01, 1, 0);
        vectors++;
        if (rcount !== 2 || rdat[1] !== exp_data(32'h40, 2'b01, 1)) begin
            miscompares++;
            $display("FAIL post_reset_read: beats=%0d data=%h want 2/%h", rcount, rdat[1], exp_data(32'h40, 2'b01, 1));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_bv[i] = '0; end
        test_reset();
        test_single();
        test_strobe();
        test_burst_stall();
        test_bresp_hold();
        test_concurrent();
        test_high_addr();
        test_random();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
